// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit
// frames with parity/stop/timeout checks, tracks shift/break/extended
// prefixes, translates make codes to ASCII and buffers them in a FWFT FIFO.
// Ports:
//   SYS_CLK, reset      system clock, synchronous active-high reset
//   ps2_clk, ps2_in     raw PS/2 clock and data (asynchronous, idle high)
//   KB_read_en          pop FIFO head (ignored when empty)
//   KB_clear            flush FIFO and clear KB_overflow
//   KB_status           FIFO non-empty
//   KB_data             ASCII at FIFO head, 0 when empty
//   KB_overflow         sticky: a character was dropped on a full FIFO
//   frame_err           one-cycle pulse on parity/start/stop error or timeout
module ps2_kb_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       SYS_CLK,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_in,
    input  logic       KB_read_en,
    input  logic       KB_clear,
    output logic       KB_status,
    output logic [6:0] KB_data,
    output logic       KB_overflow,
    output logic       frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Make-code to ASCII lookup; returns {hit, ascii}
    function automatic logic [7:0] translate(input logic [7:0] sc, input logic shifted);
        logic [6:0] lower;
        logic       letter;
        logic       hit;
        logic [6:0] ch;
        letter = 1'b1;
        lower  = 7'h00;
        case (sc)
            8'h1C: lower = 7'h61;  8'h32: lower = 7'h62;  8'h21: lower = 7'h63;
            8'h23: lower = 7'h64;  8'h24: lower = 7'h65;  8'h2B: lower = 7'h66;
            8'h34: lower = 7'h67;  8'h33: lower = 7'h68;  8'h43: lower = 7'h69;
            8'h3B: lower = 7'h6A;  8'h42: lower = 7'h6B;  8'h4B: lower = 7'h6C;
            8'h3A: lower = 7'h6D;  8'h31: lower = 7'h6E;  8'h44: lower = 7'h6F;
            8'h4D: lower = 7'h70;  8'h15: lower = 7'h71;  8'h2D: lower = 7'h72;
            8'h1B: lower = 7'h73;  8'h2C: lower = 7'h74;  8'h3C: lower = 7'h75;
            8'h2A: lower = 7'h76;  8'h1D: lower = 7'h77;  8'h22: lower = 7'h78;
            8'h35: lower = 7'h79;  8'h1A: lower = 7'h7A;
            default: letter = 1'b0;
        endcase
        hit = letter;
        ch  = shifted ? (lower - 7'h20) : lower;
        if (!letter) begin
            hit = 1'b1;
            case (sc)
                8'h45: ch = 7'h30;  8'h16: ch = 7'h31;  8'h1E: ch = 7'h32;
                8'h26: ch = 7'h33;  8'h25: ch = 7'h34;  8'h2E: ch = 7'h35;
                8'h36: ch = 7'h36;  8'h3D: ch = 7'h37;  8'h3E: ch = 7'h38;
                8'h46: ch = 7'h39;  8'h29: ch = 7'h20;  8'h5A: ch = 7'h0D;
                8'h66: ch = 7'h08;
                default: begin
                    hit = 1'b0;
                    ch  = 7'h00;
                end
            endcase
        end
        return {hit, ch};
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat;
    logic                   fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] idle_cnt;
    logic          code_valid;
    logic [7:0]    code;

    logic          shift;
    logic          brk;
    logic          ext;
    logic [7:0]    lookup;
    logic          push_valid;
    logic [6:0]    push_data;

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;

    // Synchronisers and falling-edge detect; idle-high lines reset to 1
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_in};
            clk_prev <= clk_s;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat   = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    // Frame deserialiser with timeout abort
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par        <= 1'b0;
            idle_cnt   <= '0;
            code_valid <= 1'b0;
            code       <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat;
                        state <= STOP;
                    end
                    STOP: begin
                        if (dat && (^{shreg, par})) begin
                            code_valid <= 1'b1;
                            code       <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (idle_cnt == TW'(TIMEOUT_CYCLES)) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    idle_cnt  <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    assign lookup = translate(code, shift);

    // Prefix tracking and translation register
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            shift      <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            push_valid <= 1'b0;
            push_data  <= 7'h00;
        end else begin
            push_valid <= 1'b0;
            if (code_valid) begin
                if (code == 8'hF0) begin
                    brk <= 1'b1;
                end else if (code == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (code == 8'h12 || code == 8'h59) begin
                        shift <= ~brk;
                    end else if (!brk && !ext) begin
                        push_valid <= lookup[7];
                        push_data  <= lookup[6:0];
                    end
                end
            end
        end
    end

    // FIFO: a full FIFO still accepts a push when the head is popped that cycle
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = KB_read_en & ~empty;
    assign wr_en = push_valid & ~KB_clear & (~full | pop);

    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            KB_overflow <= 1'b0;
        end else if (KB_clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            KB_overflow <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (push_valid && full && !pop) KB_overflow <= 1'b1;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign KB_status = ~empty;
    assign KB_data   = empty ? 7'h00 : mem[rd_ptr[AW-1:0]];

endmodule
